// File: rtl/serneg_ctrl.sv
// serneg_ctrl: arbitrates two requesters onto an external bit-serial
// two's-complement unit. The winner's operand is shifted out LSB first
// on ser_x after one settle cycle, and the unit's serial result on ser_y
// is collected into rsp_data.
// Optional build macro SERNEG_OVF_EN adds rsp_ovf, which flags the
// most-negative operand (its negation cannot be represented).
module serneg_ctrl #(
  parameter int unsigned FRAME = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [FRAME-1:0] data0,
  input  logic [FRAME-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [FRAME-1:0] rsp_data,
  output logic             ser_rst_n,
  output logic             ser_x,
`ifdef SERNEG_OVF_EN
  output logic             rsp_ovf,
`endif
  input  logic             ser_y
);

  localparam int unsigned      CW      = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(FRAME - 1);
  localparam logic [FRAME-1:0] MIN_NEG = {1'b1, {(FRAME-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             settle;
  logic             last;      // last-served requester, also the current winner
  logic [FRAME-1:0] operand;
  logic [FRAME-1:0] result;
  logic [FRAME-1:0] next_result;
  logic             win_id;
  logic [FRAME-1:0] win_data;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins
  always_comb begin
    win_id = 1'b0;
    if (req == 2'b11) begin
      win_id = ~last;
    end else begin
      win_id = req[1] & ~req[0];
    end
    win_data = win_id ? data1 : data0;
  end

  // Result with the bit arriving this cycle merged in, so the last bit lands directly in rsp_data
  always_comb begin
    next_result      = result;
    next_result[cnt] = ser_y;
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      settle    <= 1'b0;
      last      <= 1'b1;
      operand   <= '0;
      result    <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      ser_rst_n <= 1'b0;
      ser_x     <= 1'b0;
`ifdef SERNEG_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          ser_rst_n <= 1'b0;
          ser_x     <= 1'b0;
          if (req != '0) begin
            operand   <= win_data;
            last      <= win_id;
            gnt       <= win_id ? 2'b10 : 2'b01;
            cnt       <= '0;
            settle    <= 1'b1;
            ser_rst_n <= 1'b1;
            ser_x     <= win_data[0];
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (settle) begin
            // bit 0 stays on ser_x while the unit leaves frame reset
            settle <= 1'b0;
          end else begin
            result <= next_result;
            if (cnt == LAST) begin
              rsp_valid <= 1'b1;
              rsp_id    <= last;
              rsp_data  <= next_result;
              ser_rst_n <= 1'b0;
              ser_x     <= 1'b0;
`ifdef SERNEG_OVF_EN
              rsp_ovf   <= (operand == MIN_NEG);
`endif
              state     <= DONE;
            end else begin
              cnt   <= cnt + CW'(1);
              ser_x <= operand[cnt + CW'(1)];
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          ser_rst_n <= 1'b0;
          ser_x     <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serneg_ctrl.sv
// Bench for serneg_ctrl: a bit-serial negation unit model (with a one-flop
// internal reset stage) is attached; expected responses are queued when a
// request is driven and compared when rsp_valid appears.
module tb_serneg_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = '0;
  logic [3:0] data0 = '0;
  logic [3:0] data1 = '0;
  logic [1:0] gnt;
  logic       busy;
  logic       rsp_valid;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       ser_rst_n;
  logic       ser_x;
  logic       ser_y;
`ifdef SERNEG_OVF_EN
  logic       rsp_ovf;
`endif

  typedef struct packed {
    logic       id;
    logic [3:0] data;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int prev_gnt_cyc = 0;
  logic ptr = 1'b1;
  logic stub = 1'b0;

  // serial unit model
  logic unit_rst_q = 1'b0;
  logic found = 1'b0;

  serneg_ctrl #(.FRAME(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .ser_rst_n (ser_rst_n),
    .ser_x     (ser_x),
`ifdef SERNEG_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .ser_y     (ser_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unit: registered frame reset, then y = x ^ (a one has been seen)
  always @(posedge clk) begin
    unit_rst_q <= ser_rst_n;
    if (!unit_rst_q) found <= 1'b0;
    else             found <= found | ser_x;
  end

  assign ser_y = stub ? ser_x : (ser_x ^ found);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
`ifdef SERNEG_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // One transaction: drive, predict, follow the frame cycle by cycle
  task automatic run_txn(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                         input bit keep, input bit chk_space);
    logic       w;
    logic [3:0] op;
    exp_t       e;
    bit         seen;
    if (req != r) @(negedge clk);
    req   = r;
    data0 = d0;
    data1 = d1;
    w  = (r == 2'b11) ? ~ptr : (r == 2'b10);
    ptr = w;
    op = w ? d1 : d0;
    e.id   = w;
    e.data = stub ? op : (~op + 4'd1);
    e.ovf  = (op == 4'b1000);
    sb.push_back(e);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      check("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    check("gnt", 32'(gnt), w ? 32'd2 : 32'd1);
    if (chk_space) check("gnt_spacing", 32'(cyc - prev_gnt_cyc), 32'd7);
    prev_gnt_cyc = cyc;
    check("shift_c0", 32'({busy, ser_rst_n, ser_x}), 32'({2'b11, op[0]}));
    if (!keep) req = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("shift_bit", 32'({busy, ser_rst_n, ser_x, rsp_valid}),
            32'({2'b11, (k <= 1) ? op[0] : op[k-1], 1'b0}));
    end
    @(negedge clk);
    check("done", 32'({busy, ser_rst_n, ser_x, rsp_valid}), 32'b1001);
    @(negedge clk);
    check("idle", 32'({busy, ser_rst_n, rsp_valid, rsp_data}), 32'({3'b000, e.data}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({gnt, busy, rsp_valid, rsp_id, rsp_data, ser_rst_n, ser_x}), 32'd0);
    reset_n = 1'b1;

    run_txn(2'b01, 4'b0011, 4'b0000, 0, 0);   // -> 1101
    run_txn(2'b01, 4'b0000, 4'b0000, 0, 0);   // -> 0000
    run_txn(2'b01, 4'b1000, 4'b0000, 0, 0);   // -> 1000, overflow
    run_txn(2'b10, 4'b0000, 4'b0111, 0, 0);   // -> 1001, id 1

    // both held: 0,1,0,1 at 7-cycle spacing
    run_txn(2'b11, 4'b0001, 4'b0010, 1, 0);
    run_txn(2'b11, 4'b0001, 4'b0010, 1, 1);
    run_txn(2'b11, 4'b0001, 4'b0010, 1, 1);
    run_txn(2'b11, 4'b0001, 4'b0010, 0, 1);

    // loopback unit: result equals operand, exposing bit order
    stub = 1'b1;
    run_txn(2'b10, 4'b0000, 4'b1010, 0, 0);
    run_txn(2'b01, 4'b0110, 4'b0000, 0, 0);
    stub = 1'b0;

    // reset mid-frame
    @(negedge clk);
    req   = 2'b01;
    data0 = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
    end
    check("rst_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async", 32'({busy, ser_rst_n, ser_x, gnt, rsp_valid}), 32'd0);
    ptr = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_rsp", 32'(sb.size()), 32'd0);
    run_txn(2'b11, 4'b0110, 4'b0011, 0, 0);  // requester 0 wins -> 1010

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serneg_ctrl.md
SERNEG_CTRL -- requirements
Module: serneg_ctrl

Interface
REQ-001 Parameter: FRAME, 4, bits per serial frame; SHALL equal the attached bit-serial two's-complement unit's frame length; only 4 is supported.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  2  per-requester request, level; bit i = requester i.
REQ-005 data0, data1  in  4 each  operand of requester 0 and 1; sampled on the grant edge.
REQ-006 gnt  out  2  one-hot, registered, one-cycle pulse marking operand capture.
REQ-007 busy  out  1  high in SHIFT and DONE.
REQ-008 rsp_valid  out  1  one-cycle pulse; result available.
REQ-009 rsp_id  out  1  requester index of the current result.
REQ-010 rsp_data  out  4  two's complement of the captured operand.
REQ-011 ser_rst_n  out  1  registered, active-low frame reset to the serial unit.
REQ-012 ser_x  out  1  serial operand bit, LSB first.
REQ-013 ser_y  in  1  serial result bit from the unit (Mealy, same cycle as ser_x).

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE: ser_rst_n=0; if req!=0 at the edge, the winner's operand is latched, gnt pulses for the winner, bit counter=0, ser_rst_n<=1, next state SHIFT.
REQ-016 Arbitration SHALL be round-robin: a single requester always wins; when both request, the one not served last wins; the last-served pointer resets to 1 so requester 0 wins first.
REQ-017 SHIFT, grant edge+1 through grant edge+4: ser_x=operand[cnt]; ser_y is captured into result[cnt] at each edge; cnt increments; after cnt=3, next state DONE.
REQ-018 SHIFT, grant edge+1 SHALL be a settle cycle with cnt=0 and ser_x=operand[0] held; bits 0..3 are then captured on edges +2..+5.
REQ-019 DONE: rsp_valid=1, rsp_id=winner, rsp_data=result, ser_rst_n=0; next state IDLE.
REQ-020 Latency: rsp_valid is high in the cycle following edge +5 after the gnt edge; minimum spacing between grants is 7 cycles.
REQ-021 Requests are only accepted in IDLE; req changes in SHIFT and DONE are ignored; a held req re-arbitrates in IDLE.
REQ-022 rsp_data and rsp_id SHALL hold until the next rsp_valid.
REQ-023 ser_rst_n SHALL be low for at least 2 cycles (DONE and IDLE) between frames.

Reset
REQ-024 reset_n low SHALL force: state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, ser_rst_n=0, ser_x=0, cnt=0, pointer=1.
REQ-025 Reset during SHIFT or DONE SHALL discard the operation; no rsp_valid is produced for it.

Configuration
REQ-026 Macro SERNEG_OVF_EN: when defined, output rsp_ovf (1 bit, reset 0) is updated with rsp_data and is 1 only when the operand was 4'b1000; when undefined, the port and its logic SHALL be absent and all other behaviour is identical.

Verification
REQ-027 req=01, data0=4'b0011 with the unit model attached -> gnt=01; ser_x=1 in the settle cycle and bits 1,1,0,0; rsp_valid with rsp_id=0 and rsp_data=4'b1101.
REQ-028 Operands 4'b0000 and 4'b1000 -> rsp_data 4'b0000 and 4'b1000; with SERNEG_OVF_EN, rsp_ovf is 0 and then 1.
REQ-029 Both req held, data0=4'b0001, data1=4'b0010 -> grant order 0,1,0,1; rsp_data 4'b1111 and 4'b1110 alternating.
REQ-030 ser_y stubbed to ser_x, data1=4'b1010 -> rsp_data=4'b1010, confirming LSB-first capture order.
REQ-031 reset_n pulsed low during SHIFT -> no rsp_valid, busy=0 and ser_rst_n=0 immediately; the next request completes correctly with requester 0 winning.
